assoc_inst_cache: RTL and testbench

ASSOC_INST_CACHE -- requirements
Module: assoc_inst_cache

---
 rtl/assoc_inst_cache.sv | 186 ++++++++++++++++++
 tb/tb_assoc_inst_cache.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/assoc_inst_cache.sv
// N-way set-associative instruction cache with AXI4 burst refill; hit latency 0 cycles, miss = AR handshake + beats + 2.
// Refill stalls on arready/rvalid; invalidates are serviced only in IDLE and take priority over reads.
// Optional hit/miss counters enabled with `define ICACHE_PERF_COUNTER_EN.
module assoc_inst_cache #(
    parameter int WAYS         = 2,
    parameter int INDEX_WIDTH  = 6,
    parameter int OFFSET_WIDTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read_en,
    input  logic [31:0] addr_read,
    output logic        ready,
    output logic [31:0] data_out,
    input  logic        hit_invalidate,
    input  logic [31:0] addr_invalidate,
    output logic        inv_ack,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
`ifdef ICACHE_PERF_COUNTER_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int TAG_LSB = INDEX_WIDTH + OFFSET_WIDTH + 2;
    localparam int TAG_W   = 32 - TAG_LSB;
    localparam int SETS    = 1 << INDEX_WIDTH;
    localparam int WORDS   = 1 << OFFSET_WIDTH;
    localparam int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_UPDATE} state_t;

    state_t                  r_state, w_next;
    logic [WAYS-1:0]         r_valid [SETS];
    logic [TAG_W-1:0]        r_tag   [WAYS][SETS];
    logic [31:0]             r_mem   [WAYS][SETS][WORDS];
    logic [WAY_W-1:0]        r_rr    [SETS];
    logic [WAY_W-1:0]        r_victim;
    logic [31:0]             r_araddr;
    logic [OFFSET_WIDTH-1:0] r_beat;

    logic [TAG_W-1:0]        w_rd_tag, w_inv_tag, w_fill_tag;
    logic [INDEX_WIDTH-1:0]  w_rd_idx, w_inv_idx, w_fill_idx;
    logic [OFFSET_WIDTH-1:0] w_rd_off;
    logic [WAYS-1:0]         w_hit_way;
    logic                    w_hit, w_idle, w_inv_fire, w_rd_fire, w_miss, w_has_inv;
    logic [31:0]             w_hit_data;
    logic [WAY_W-1:0]        w_victim, w_rr_next;
    logic                    w_unused;

    assign w_rd_tag   = addr_read[31:TAG_LSB];
    assign w_rd_idx   = addr_read[TAG_LSB-1:OFFSET_WIDTH+2];
    assign w_rd_off   = addr_read[OFFSET_WIDTH+1:2];
    assign w_inv_tag  = addr_invalidate[31:TAG_LSB];
    assign w_inv_idx  = addr_invalidate[TAG_LSB-1:OFFSET_WIDTH+2];
    assign w_fill_tag = r_araddr[31:TAG_LSB];
    assign w_fill_idx = r_araddr[TAG_LSB-1:OFFSET_WIDTH+2];
    assign w_unused   = ^{addr_read[1:0], addr_invalidate[OFFSET_WIDTH+1:0], rid, rresp};

    always_comb begin
        w_hit_way  = '0;
        w_hit_data = '0;
        for (int w = 0; w < WAYS; w++) begin
            w_hit_way[w] = r_valid[w_rd_idx][w] && (r_tag[w][w_rd_idx] == w_rd_tag);
            if (w_hit_way[w]) w_hit_data = w_hit_data | r_mem[w][w_rd_idx][w_rd_off];
        end
    end
    assign w_hit = |w_hit_way;

    // Invalidate wins over a simultaneous read; the read retries next cycle.
    assign w_idle     = (r_state == S_IDLE) && !rst;
    assign w_inv_fire = w_idle && hit_invalidate;
    assign w_rd_fire  = w_idle && read_en && !hit_invalidate;
    assign w_miss     = w_rd_fire && !w_hit;

    always_comb begin
        w_has_inv = 1'b0;
        w_victim  = r_rr[w_rd_idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w_rd_idx][w]) begin
                w_has_inv = 1'b1;
                w_victim  = WAY_W'(w);
            end
        end
        w_rr_next = (r_rr[w_rd_idx] == WAY_W'(WAYS - 1)) ? '0 : r_rr[w_rd_idx] + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_miss) w_next = S_ADDR;
            S_ADDR:   if (arready) w_next = S_DATA;
            S_DATA:   if (rvalid && rlast) w_next = S_UPDATE;
            S_UPDATE: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        ready    = w_rd_fire && w_hit;
        data_out = ready ? w_hit_data : 32'd0;
        inv_ack  = w_inv_fire;
        arvalid  = (r_state == S_ADDR);
        rready   = (r_state == S_DATA);
        araddr   = r_araddr;
        arid     = 4'd0;
        arlen    = 8'(WORDS - 1);
        arsize   = 3'b010;
        arburst  = 2'b01;
        arlock   = 2'd0;
        arcache  = 4'd0;
        arprot   = 3'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_araddr <= '0;
            r_victim <= '0;
            r_beat   <= '0;
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_rr[s]    <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_miss) begin
                        r_araddr <= {addr_read[31:OFFSET_WIDTH+2], {(OFFSET_WIDTH+2){1'b0}}};
                        r_victim <= w_victim;
                        r_beat   <= '0;
                        if (!w_has_inv) r_rr[w_rd_idx] <= w_rr_next;
                    end
                    if (w_inv_fire) begin
                        for (int w = 0; w < WAYS; w++) begin
                            if (r_valid[w_inv_idx][w] && (r_tag[w][w_inv_idx] == w_inv_tag))
                                r_valid[w_inv_idx][w] <= 1'b0;
                        end
                    end
                end
                S_DATA:   if (rvalid) r_beat <= r_beat + 1'b1;
                S_UPDATE: r_valid[w_fill_idx][r_victim] <= 1'b1;
                default: ;
            endcase
        end
    end

    // Line storage needs no reset: a line is only visible once its valid bit is set.
    always_ff @(posedge clk) begin
        if (r_state == S_DATA && rvalid) r_mem[r_victim][w_fill_idx][r_beat] <= rdata;
        if (r_state == S_UPDATE)         r_tag[r_victim][w_fill_idx] <= w_fill_tag;
    end

`ifdef ICACHE_PERF_COUNTER_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (ready)  hit_count  <= hit_count + 32'd1;
            if (w_miss) miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_assoc_inst_cache.sv
// Directed bench for assoc_inst_cache (default parameters); acts as the AXI read slave.
module tb_assoc_inst_cache;
    logic        clk = 1'b0;
    logic        rst;
    logic        read_en, hit_invalidate, arready, rlast, rvalid;
    logic [31:0] addr_read, addr_invalidate, rdata;
    logic [3:0]  rid;
    logic [1:0]  rresp;
    logic        ready, inv_ack, arvalid, rready;
    logic [31:0] data_out, araddr;
    logic [3:0]  arid, arcache;
    logic [7:0]  arlen;
    logic [2:0]  arsize, arprot;
    logic [1:0]  arburst, arlock;
`ifdef ICACHE_PERF_COUNTER_EN
    logic [31:0] hit_count, miss_count;
`endif
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assoc_inst_cache dut (
        .clk(clk), .rst(rst), .read_en(read_en), .addr_read(addr_read), .ready(ready),
        .data_out(data_out), .hit_invalidate(hit_invalidate), .addr_invalidate(addr_invalidate),
        .inv_ack(inv_ack), .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp),
        .rlast(rlast), .rvalid(rvalid), .rready(rready)
`ifdef ICACHE_PERF_COUNTER_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic wait_ar();
        int n = 0;
        while (!arvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ar_vld", {31'd0, arvalid}, 32'd1);
    endtask

    // Entered and left at posedge+1; a miss is served by a 16-beat burst of base+k.
    task automatic do_read(input logic [31:0] a, input bit miss,
                           input logic [31:0] base, input logic [31:0] exp);
        read_en   = 1'b1;
        addr_read = a;
        @(negedge clk);
        if (!miss) begin
            chk("hit_rdy", {31'd0, ready}, 32'd1);
            chk("hit_dat", data_out, exp);
        end else begin
            chk("miss_rdy", {31'd0, ready}, 32'd0);
            chk("miss_dat", data_out, 32'd0);
            wait_ar();
            chk("araddr", araddr, a & 32'hFFFF_FFC0);
            chk("arlen", {24'd0, arlen}, 32'd15);
            chk("arsize_burst", {27'd0, arsize, arburst}, {27'd0, 3'b010, 2'b01});
            arready = 1'b1;
            @(posedge clk); #1;
            arready = 1'b0;
            for (int k = 0; k < 16; k++) begin
                rvalid = 1'b1;
                rdata  = base + 32'(k);
                rlast  = (k == 15);
                @(negedge clk);
                if (k == 0) chk("rready", {31'd0, rready}, 32'd1);
                @(posedge clk); #1;
            end
            rvalid = 1'b0;
            rlast  = 1'b0;
            @(negedge clk);
            chk("upd_rdy", {31'd0, ready}, 32'd0);
            @(negedge clk);
            chk("fill_rdy", {31'd0, ready}, 32'd1);
            chk("fill_dat", data_out, exp);
        end
        @(posedge clk); #1;
        read_en = 1'b0;
    endtask

    task automatic do_inv(input logic [31:0] a);
        hit_invalidate  = 1'b1;
        addr_invalidate = a;
        @(negedge clk);
        chk("inv_ack", {31'd0, inv_ack}, 32'd1);
        @(posedge clk); #1;
        hit_invalidate = 1'b0;
        @(negedge clk);
        chk("inv_ack_drop", {31'd0, inv_ack}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; read_en = 1'b0; hit_invalidate = 1'b0; arready = 1'b0;
        rlast = 1'b0; rvalid = 1'b0; addr_read = '0; addr_invalidate = '0;
        rdata = '0; rid = 4'd3; rresp = 2'd2;
        @(negedge clk);
        chk("rst_out", {26'd0, ready, inv_ack, arvalid, rready, 2'b00}, 32'd0);
        chk("rst_dat", data_out, 32'd0);
        chk("rst_araddr", araddr, 32'd0);
        chk("rst_arfields", {19'd0, arid, arlock, arcache, arprot}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Cold miss and hits in the same line (set 0, tag 1 -> way 0).
        do_read(32'h0000_1004, 1, 32'h100, 32'h101);
        do_read(32'h0000_1008, 0, 32'h0, 32'h102);
        do_read(32'h0000_103C, 0, 32'h0, 32'h10F);
        // Second line fills way 1, third evicts way 0 by round robin.
        do_read(32'h0000_2000, 1, 32'h200, 32'h200);
        do_read(32'h0000_1000, 0, 32'h0, 32'h100);
        do_read(32'h0000_2004, 0, 32'h0, 32'h201);
        do_read(32'h0000_3000, 1, 32'h300, 32'h300);
        do_read(32'h0000_2000, 0, 32'h0, 32'h200);
        do_read(32'h0000_1000, 1, 32'h400, 32'h400);
        do_read(32'h0000_3004, 0, 32'h0, 32'h301);

        // Invalidate by any address in the line; a non-matching invalidate still acks.
        do_inv(32'h0000_1010);
        do_read(32'h0000_1000, 1, 32'h500, 32'h500);
        do_inv(32'h0000_7000);
        do_read(32'h0000_3000, 0, 32'h0, 32'h300);

        // Read and invalidate of the same line together: invalidate first, then refill.
        read_en = 1'b1; addr_read = 32'h0000_3000;
        hit_invalidate = 1'b1; addr_invalidate = 32'h0000_3000;
        @(negedge clk);
        chk("col_ack", {31'd0, inv_ack}, 32'd1);
        chk("col_rdy", {31'd0, ready}, 32'd0);
        @(posedge clk); #1;
        hit_invalidate = 1'b0;
        do_read(32'h0000_3000, 1, 32'h600, 32'h600);

        // Reset after beat 7 of a burst; leftover beats must be ignored.
        read_en = 1'b1; addr_read = 32'h0000_5008;
        @(negedge clk);
        wait_ar();
        arready = 1'b1;
        @(posedge clk); #1;
        arready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            rvalid = 1'b1; rdata = 32'hDEAD_0000 + 32'(k);
            @(posedge clk); #1;
        end
        rvalid = 1'b0; rst = 1'b1; read_en = 1'b0;
        @(negedge clk);
        chk("mrst_out", {28'd0, ready, inv_ack, arvalid, rready}, 32'd0);
        chk("mrst_araddr", araddr, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 8; k < 16; k++) begin
            rvalid = 1'b1; rdata = 32'hDEAD_0000 + 32'(k); rlast = (k == 15);
            @(negedge clk);
            chk("stray_idle", {30'd0, arvalid, rready}, 32'd0);
            @(posedge clk); #1;
        end
        rvalid = 1'b0; rlast = 1'b0;
        do_read(32'h0000_5008, 1, 32'h700, 32'h702);
        do_read(32'h0000_5000, 0, 32'h0, 32'h700);
        do_read(32'h0000_5004, 0, 32'h0, 32'h701);
`ifdef ICACHE_PERF_COUNTER_EN
        // Every ready pulse counts, including the one closing the refill.
        @(negedge clk);
        chk("miss_count", miss_count, 32'd1);
        chk("hit_count", hit_count, 32'd3);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
